// File: rtl/inst_fetch.sv
// Instruction fetch unit: assembles a 32-bit little-endian instruction from four
// byte reads and hands it with its PC to the if_id stage, stalling the PC meanwhile.
module inst_fetch #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              jump_i,
    input  logic              id_stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stallreq_o
);

    // state | meaning
    // IDLE  | waiting for ce_i, latches pc_i as fetch base
    // FETCH | requesting byte base+cnt, collecting into inst
    // DRAIN | redirected; waiting out the in-flight byte, data dropped
    // VALID | instruction presented to if_id
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            base_q    <= '0;
            inst_q    <= 32'd0;
            inst_pc_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ce_i) begin
                        base_q  <= pc_i;
                        cnt_q   <= 2'd0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (jump_i) begin
                        // cnt_q is left alone so DRAIN keeps the same address
                        state_q <= mem_ack_i ? S_IDLE : S_DRAIN;
                    end else if (mem_ack_i) begin
                        inst_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            inst_pc_q <= base_q;
                            state_q   <= S_VALID;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_ack_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_VALID: begin
                    if (jump_i || !id_stall_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req_o    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign mem_addr_o   = mem_req_o ? (base_q + {{(ADDR_W-2){1'b0}}, cnt_q}) : '0;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = (state_q == S_VALID);
    assign stallreq_o   = !((state_q == S_VALID) && !id_stall_i && !jump_i);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table, hand-written corner sequences,
// and a randomized run against a transaction-level memory/latency model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i, jump_i, id_stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o, stallreq_o;

    inst_fetch #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .jump_i(jump_i),
        .id_stall_i(id_stall_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit manual = 1'b0;
    int fixed_wait = 0;
    bit pend = 1'b0;
    int wleft = 0;
    int wsum = 0;

    typedef struct {
        logic        ce, stall, jump;
        logic        req;
        logic [31:0] addr;
        logic        valid, sreq;
        bit          chk_inst;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5a;
        endcase
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock; the memory model answers right after the edge so an ack can
    // land in the very cycle a request first appears.
    task automatic step();
        @(posedge clk);
        #1;
        if (!manual) begin
            if (mem_req_o) begin
                if (!pend) begin
                    pend  = 1'b1;
                    wleft = (fixed_wait < 0) ? int'($urandom_range(0, 2)) : fixed_wait;
                    wsum += wleft;
                end
                if (wleft == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_byte(mem_addr_o);
                    pend        = 1'b0;
                end else begin
                    mem_ack_i = 1'b0;
                    wleft--;
                end
            end else begin
                mem_ack_i = 1'b0;
                pend      = 1'b0;
            end
        end
        #1;
    endtask

    // Start in IDLE, fetch pc, expect valid after lat clocks and consume it.
    task automatic fetch_expect(input logic [31:0] pc, input int lat, input string nm);
        int c;
        c = 0;
        ce_i = 1'b1; pc_i = pc; id_stall_i = 1'b0; jump_i = 1'b0;
        #1;
        while (!inst_valid_o && c < 200) begin
            step();
            c++;
        end
        ce_i = 1'b0;
        chk({nm, " latency"}, 32'(c), 32'(lat));
        chk({nm, " inst"}, inst_o, exp_inst(pc));
        chk({nm, " pc"}, inst_pc_o, pc);
        #1;
        chk({nm, " stallreq consume"}, 32'(stallreq_o), 32'd0);
        step();
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " req"}, 32'(mem_req_o), 32'd0);
        chk({nm, " addr"}, mem_addr_o, 32'd0);
        chk({nm, " inst"}, inst_o, 32'd0);
        chk({nm, " inst_pc"}, inst_pc_o, 32'd0);
        chk({nm, " valid"}, 32'(inst_valid_o), 32'd0);
        chk({nm, " stallreq"}, 32'(stallreq_o), 32'd1);
    endtask

    initial begin
        logic [31:0] pc, hold_i;
        int c, k, s;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h101, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0};

        rst = 1'b0; pc_i = 32'h100; ce_i = 1'b0; jump_i = 1'b0; id_stall_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = 8'h00;
        #3;
        chk_reset_outs("reset");
        #9 rst = 1'b1;

        // zero-wait fetch at 0x100, cycle by cycle
        fixed_wait = 0;
        for (int i = 0; i < 7; i++) begin
            ce_i = tbl[i].ce; id_stall_i = tbl[i].stall; jump_i = tbl[i].jump;
            #1;
            chk($sformatf("tbl%0d req", i), 32'(mem_req_o), 32'(tbl[i].req));
            chk($sformatf("tbl%0d addr", i), mem_addr_o, tbl[i].addr);
            chk($sformatf("tbl%0d valid", i), 32'(inst_valid_o), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d stallreq", i), 32'(stallreq_o), 32'(tbl[i].sreq));
            if (tbl[i].chk_inst) begin
                chk($sformatf("tbl%0d inst", i), inst_o, 32'h0010_0513);
                chk($sformatf("tbl%0d inst_pc", i), inst_pc_o, 32'h100);
            end
            step();
        end

        // two wait cycles per byte: each address held 3 cycles, valid in cycle 14
        fixed_wait = 2;
        ce_i = 1'b1; pc_i = 32'h100;
        #1;
        for (int cy = 2; cy <= 13; cy++) begin
            step();
            ce_i = 1'b0;
            chk("w2 req", 32'(mem_req_o), 32'd1);
            chk("w2 addr", mem_addr_o, 32'h100 + 32'((cy - 2) / 3));
        end
        step();
        chk("w2 valid c14", 32'(inst_valid_o), 32'd1);
        chk("w2 inst", inst_o, 32'h0010_0513);

        // hold in VALID with id_stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            id_stall_i = 1'b1;
            #1;
            chk("stall valid", 32'(inst_valid_o), 32'd1);
            chk("stall stallreq", 32'(stallreq_o), 32'd1);
            chk("stall inst", inst_o, 32'h0010_0513);
            chk("stall inst_pc", inst_pc_o, 32'h100);
            step();
        end
        id_stall_i = 1'b0;
        #1;
        chk("unstall stallreq", 32'(stallreq_o), 32'd0);
        step();
        chk("unstall idle valid", 32'(inst_valid_o), 32'd0);
        chk("unstall idle req", 32'(mem_req_o), 32'd0);

        // jump in FETCH at cnt=2 without ack -> DRAIN, then refetch 0x200
        manual = 1'b1; mem_ack_i = 1'b0;
        ce_i = 1'b1; pc_i = 32'h300;
        step();
        mem_ack_i = 1'b1; mem_rdata_i = mem_byte(mem_addr_o);
        step();
        mem_ack_i = 1'b1; mem_rdata_i = mem_byte(mem_addr_o);
        step();
        chk("jmp cnt2 addr", mem_addr_o, 32'h302);
        mem_ack_i = 1'b0; jump_i = 1'b1; pc_i = 32'h200;
        #1;
        chk("jmp fetch stallreq", 32'(stallreq_o), 32'd1);
        step();
        jump_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain req", 32'(mem_req_o), 32'd1);
            chk("drain addr", mem_addr_o, 32'h302);
            chk("drain valid", 32'(inst_valid_o), 32'd0);
            mem_ack_i = (i == 1);
            mem_rdata_i = 8'hee;
            step();
        end
        mem_ack_i = 1'b0;
        chk("post drain req", 32'(mem_req_o), 32'd0);
        chk("post drain valid", 32'(inst_valid_o), 32'd0);
        manual = 1'b0; pend = 1'b0; fixed_wait = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("refetch addr", mem_addr_o, 32'h200 + 32'(i));
            chk("refetch valid", 32'(inst_valid_o), 32'd0);
            step();
        end
        ce_i = 1'b0;
        chk("refetch inst", inst_o, exp_inst(32'h200));
        chk("refetch pc", inst_pc_o, 32'h200);
        chk("refetch valid", 32'(inst_valid_o), 32'd1);
        step();

        // jump coincident with an ack
        manual = 1'b1; mem_ack_i = 1'b0;
        ce_i = 1'b1; pc_i = 32'h400;
        step();
        ce_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = mem_byte(mem_addr_o);
        step();
        mem_ack_i = 1'b1; mem_rdata_i = mem_byte(mem_addr_o); jump_i = 1'b1;
        step();
        mem_ack_i = 1'b0; jump_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("jmp+ack req", 32'(mem_req_o), 32'd0);
            chk("jmp+ack valid", 32'(inst_valid_o), 32'd0);
            step();
        end
        manual = 1'b0; pend = 1'b0;

        // jump in VALID with id_stall low: dropped, not consumed
        ce_i = 1'b1; pc_i = 32'h500;
        for (int i = 0; i < 5; i++) begin
            step();
            ce_i = 1'b0;
        end
        chk("jmp valid pre", 32'(inst_valid_o), 32'd1);
        jump_i = 1'b1;
        #1;
        chk("jmp valid stallreq", 32'(stallreq_o), 32'd1);
        step();
        jump_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("jmp valid dropped", 32'(inst_valid_o), 32'd0);
            chk("jmp valid idle req", 32'(mem_req_o), 32'd0);
            step();
        end

        // async reset mid-FETCH, late ack ignored, restart afterwards
        manual = 1'b1; mem_ack_i = 1'b0;
        ce_i = 1'b1; pc_i = 32'h600;
        step();
        chk("rst pre req", 32'(mem_req_o), 32'd1);
        chk("rst pre addr", mem_addr_o, 32'h600);
        #2 rst = 1'b0;
        #1;
        chk_reset_outs("async rst");
        ce_i = 1'b0;
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 8'hc3;
        rst = 1'b1;
        #1;
        chk("late ack req", 32'(mem_req_o), 32'd0);
        step();
        chk("late ack inst", inst_o, 32'd0);
        chk("late ack valid", 32'(inst_valid_o), 32'd0);
        mem_ack_i = 1'b0; manual = 1'b0; pend = 1'b0; fixed_wait = 0;
        fetch_expect(32'h700, 5, "after rst");

        // randomized: random PCs, waits 0..2 per byte, random id_stall holds
        fixed_wait = -1;
        for (int n = 0; n < 40; n++) begin
            pc = (n == 0) ? 32'hFFFF_FFFE : $urandom;
            c = 0; k = 0; wsum = 0;
            ce_i = 1'b1; pc_i = pc;
            #1;
            while (!inst_valid_o && c < 200) begin
                step();
                c++;
                if (mem_req_o && mem_ack_i) begin
                    chk("rnd ack addr", mem_addr_o, pc + 32'(k));
                    k++;
                end
            end
            ce_i = 1'b0;
            chk("rnd latency", 32'(c), 32'(5 + wsum));
            chk("rnd bytes", 32'(k), 32'd4);
            chk("rnd inst", inst_o, exp_inst(pc));
            chk("rnd pc", inst_pc_o, pc);
            hold_i = exp_inst(pc);
            s = int'($urandom_range(0, 2));
            for (int i = 0; i < s; i++) begin
                id_stall_i = 1'b1;
                #1;
                chk("rnd stall stallreq", 32'(stallreq_o), 32'd1);
                chk("rnd stall inst", inst_o, hold_i);
                step();
            end
            id_stall_i = 1'b0;
            #1;
            chk("rnd consume stallreq", 32'(stallreq_o), 32'd0);
            step();
            if ($urandom_range(0, 1) == 1) begin
                chk("rnd idle req", 32'(mem_req_o), 32'd0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit between `pc_reg` and the `if_id` pipeline register. It latches the current fetch address, reads a 32-bit instruction over the byte-wide memory bus as four sequential byte transactions, and presents the assembled instruction and its PC to `if_id`. While no instruction is ready it raises a stall request to `ctrl`, so that `pc_reg` holds `pc`. A jump redirect from `ex` aborts the in-flight fetch and drains any outstanding byte transaction.

## Interface
- ADDR_W, 32, width of instruction addresses and of `inst_pc_o`
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- pc_i  input  ADDR_W  fetch address from `pc_reg`
- ce_i  input  1  chip enable from `pc_reg`; 1 = fetching allowed
- jump_i  input  1  redirect from `ex`; 1 = discard current fetch
- id_stall_i  input  1  `if_id` cannot accept this cycle
- mem_req_o  output  1  byte read request
- mem_addr_o  output  ADDR_W  byte address of the request
- mem_rdata_i  input  8  returned byte, valid when `mem_ack_i` = 1
- mem_ack_i  input  1  completes the current byte request
- inst_o  output  32  assembled instruction
- inst_pc_o  output  ADDR_W  address of `inst_o`
- inst_valid_o  output  1  `inst_o` and `inst_pc_o` valid
- stallreq_o  output  1  stall request to `ctrl`

## Operation
- FSM states:
  - IDLE
  - FETCH (2-bit byte counter `cnt`)
  - DRAIN
  - VALID
- IDLE:
  - If `ce_i` = 1: `base` <= `pc_i`, `cnt` <= 0, next state FETCH.
  - Otherwise stay in IDLE.
  - `jump_i` has no effect in IDLE; `pc_i` already carries the target.
- FETCH:
  - `mem_req_o` = 1, `mem_addr_o` = `base` + `cnt`, using ADDR_W-bit wrapping addition.
  - On `mem_ack_i` = 1: `inst_o[8*cnt+7:8*cnt]` <= `mem_rdata_i` (little-endian), then `cnt` <= `cnt` + 1.
  - On the ack with `cnt` = 3, next state is VALID and `inst_pc_o` <= `base`.
- VALID:
  - `inst_valid_o` = 1.
  - If `id_stall_i` = 0: the instruction is consumed this cycle and the next state is IDLE.
  - If `id_stall_i` = 1: hold the state; `inst_o` and `inst_pc_o` stay stable.
- Jump handling (`jump_i` = 1):
  - In VALID: the instruction is dropped, not consumed even if `id_stall_i` = 0; next state IDLE.
  - In FETCH with `mem_ack_i` = 1 in the same cycle: the byte is discarded; next state IDLE.
  - In FETCH with `mem_ack_i` = 0: next state DRAIN.
  - In DRAIN: ignored.
- DRAIN:
  - `mem_req_o` stays 1 and `mem_addr_o` stays unchanged.
  - On `mem_ack_i` = 1: the data is discarded; next state IDLE.
- `stallreq_o` = 0 only in VALID with `id_stall_i` = 0 and `jump_i` = 0; it is 1 in every other state and case.
- `ce_i` = 0 outside IDLE: the current fetch completes normally; only IDLE checks `ce_i`.
- Memory protocol:
  - At most one outstanding byte.
  - `mem_addr_o` is stable while `mem_req_o` = 1 and until the ack.
  - An ack may arrive in the same cycle the request is first asserted.
  - Acks while `mem_req_o` = 0 are ignored.

## Timing
- Reset values: state IDLE, `cnt` = 0, `base` = 0.
- Output reset values:
  - `mem_req_o` = 0, `mem_addr_o` = 0
  - `inst_o` = 0, `inst_pc_o` = 0
  - `inst_valid_o` = 0, `stallreq_o` = 1
- All state is registered.
- `mem_req_o`, `mem_addr_o`, `inst_valid_o` and `stallreq_o` are decoded from the registered state plus same-cycle `id_stall_i`/`jump_i` (for `stallreq_o` only).
- With zero-wait memory (ack every requested cycle):
  - 1 cycle IDLE + 4 cycles FETCH + 1 cycle VALID = 6 cycles per instruction.
  - `inst_valid_o` rises 5 cycles after the IDLE cycle that latches `pc_i`.
- Each memory wait cycle adds one cycle.
- Reset asserted mid-fetch: outputs return to reset values immediately (asynchronous). Any memory ack still outstanding after reset is ignored.

## Test plan
- Zero-wait fetch, memory[0x100..0x103] = 13 05 10 00, `pc_i` = 0x100:
  - `inst_valid_o` = 1 with `inst_o` = 0x00100513 and `inst_pc_o` = 0x100, in cycle 6.
  - `mem_addr_o` steps 0x100 through 0x103.
  - `stallreq_o` = 0 only in cycle 6.
- Memory with 2 wait cycles per byte: `inst_valid_o` rises in cycle 14. Each of the four byte addresses is held stable for 3 cycles.
- `id_stall_i` = 1 for 3 cycles during VALID:
  - `inst_o`/`inst_pc_o` stay stable and `stallreq_o` stays 1.
  - The FSM returns to IDLE the cycle after `id_stall_i` falls.
- `jump_i` pulse during FETCH (`cnt` = 2, no ack) with `pc_i` = 0x200:
  - DRAIN holds `mem_addr_o` = base+2 until the ack.
  - Next fetch addresses are 0x200..0x203, and no `inst_valid_o` occurs for the old address.
- `jump_i` coincident with an ack, and separately `jump_i` in VALID with `id_stall_i` = 0: the FSM goes straight to IDLE and the old instruction is never presented.
- `rst` = 0 asserted asynchronously mid-FETCH: all outputs go to reset values before the next clock edge. A late ack afterwards is ignored, and fetch restarts from `pc_i` after release.
